dpr_access_ctrl: RTL and testbench

Single-clock initiator for the true dual-port RAM (`tdpr`), with both RAM clocks tied to `clk`. It accepts independent valid/ready request streams on channel A and channel B, and drives the RAM's `cs`/`wr`/`addr`/`di` pins from registers. It returns read data with a fixed latency. Same-address conflicts are resolved in hardware by round-robin serialization, so the RAM never sees a same-cycle same-address access involving a write.

---
 rtl/dpr_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dpr_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpr_access_ctrl.sv
`timescale 1ns/1ps
// dpr_access_ctrl
//
// Single-clock request front end for a true dual-port RAM whose two clocks
// are both tied to clk. Two independent valid/ready request channels (A, B)
// are registered onto the RAM pins one cycle after the handshake. Read data
// comes back three cycles after the handshake.
//
// Same-address accesses involving a write are never issued to the RAM in the
// same cycle. Only the channel holding the round-robin priority is accepted,
// and the loser gets priority for the next conflict.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   a_valid/a_ready               channel A request handshake
//   a_wr, a_addr, a_wdata         channel A request (1 = write)
//   a_rvalid, a_rdata             channel A read response (one-cycle pulse)
//   b_*                           same set for channel B
//   ram_cs                        RAM chip select (either port has a command)
//   ram_wra/ram_wrb               RAM write enables
//   ram_addra/ram_addrb           RAM addresses
//   ram_dia/ram_dib               RAM write data
//   ram_doa/ram_dob               RAM read data, one cycle after sampling
//   coll_cnt                      saturating count of conflict cycles
//   busy                          a command or a read is still in flight
module dpr_access_ctrl #(
  parameter int WID_D = 4,
  parameter int WID_A = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_wr,
  input  logic [WID_A-1:0] a_addr,
  input  logic [WID_D-1:0] a_wdata,
  output logic             a_rvalid,
  output logic [WID_D-1:0] a_rdata,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_wr,
  input  logic [WID_A-1:0] b_addr,
  input  logic [WID_D-1:0] b_wdata,
  output logic             b_rvalid,
  output logic [WID_D-1:0] b_rdata,
  output logic             ram_cs,
  output logic             ram_wra,
  output logic             ram_wrb,
  output logic [WID_A-1:0] ram_addra,
  output logic [WID_A-1:0] ram_addrb,
  output logic [WID_D-1:0] ram_dia,
  output logic [WID_D-1:0] ram_dib,
  input  logic [WID_D-1:0] ram_doa,
  input  logic [WID_D-1:0] ram_dob,
  output logic [CNT_W-1:0] coll_cnt,
  output logic             busy
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  prio_t prio;
  logic  conflict;
  logic  a_acc;
  logic  b_acc;
  logic  vld_a_p1, vld_a_p2;
  logic  vld_b_p1, vld_b_p2;

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Stage p0: handshake and arbitration (combinational).
  // Two reads of the same address are harmless, so only a write makes a
  // same-address pair a conflict.
  assign conflict = a_valid && b_valid && (a_addr == b_addr) && (a_wr || b_wr);
  assign a_ready  = !rst && (!conflict || (prio == PRIO_A));
  assign b_ready  = !rst && (!conflict || (prio == PRIO_B));
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= PRIO_A;
      coll_cnt  <= '0;
      ram_cs    <= 1'b0;
      ram_wra   <= 1'b0;
      ram_wrb   <= 1'b0;
      ram_addra <= '0;
      ram_addrb <= '0;
      ram_dia   <= '0;
      ram_dib   <= '0;
      vld_a_p1  <= 1'b0;
      vld_a_p2  <= 1'b0;
      vld_b_p1  <= 1'b0;
      vld_b_p2  <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      // The loser of a conflict owns the next one.
      if (conflict) begin
        prio     <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
        coll_cnt <= sat_inc(coll_cnt);
      end

      // Stage p1: command registers drive the RAM pins.
      // An idle port keeps its address/data; its read is never tracked.
      ram_cs  <= a_acc || b_acc;
      ram_wra <= a_acc && a_wr;
      ram_wrb <= b_acc && b_wr;
      if (a_acc) begin
        ram_addra <= a_addr;
        ram_dia   <= a_wdata;
      end
      if (b_acc) begin
        ram_addrb <= b_addr;
        ram_dib   <= b_wdata;
      end
      vld_a_p1 <= a_acc && !a_wr;
      vld_b_p1 <= b_acc && !b_wr;

      // Stage p2: RAM output valid for tracked reads.
      vld_a_p2 <= vld_a_p1;
      vld_b_p2 <= vld_b_p1;

      // Stage p3: registered response.
      a_rvalid <= vld_a_p2;
      b_rvalid <= vld_b_p2;
      if (vld_a_p2) a_rdata <= ram_doa;
      if (vld_b_p2) b_rdata <= ram_dob;
    end
  end

  assign busy = ram_cs || vld_a_p1 || vld_a_p2 || vld_b_p1 || vld_b_p2;

endmodule

// File: tb/tb_dpr_access_ctrl.sv
`timescale 1ns/1ps
// Bench for dpr_access_ctrl with a behavioural read-first dual-port RAM.
module tb_dpr_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_wr, a_rvalid;
  logic [4:0] a_addr;
  logic [3:0] a_wdata, a_rdata;
  logic       b_valid, b_ready, b_wr, b_rvalid;
  logic [4:0] b_addr;
  logic [3:0] b_wdata, b_rdata;
  logic       ram_cs, ram_wra, ram_wrb;
  logic [4:0] ram_addra, ram_addrb;
  logic [3:0] ram_dia, ram_dib, ram_doa, ram_dob;
  logic [7:0] coll_cnt;
  logic       busy;

  dpr_access_ctrl #(.WID_D(4), .WID_A(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_cs(ram_cs), .ram_wra(ram_wra), .ram_wrb(ram_wrb),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dia(ram_dia), .ram_dib(ram_dib),
    .ram_doa(ram_doa), .ram_dob(ram_dob),
    .coll_cnt(coll_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, both ports on clk, read-first.
  logic [3:0] mem [32];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wra) mem[ram_addra] <= ram_dia;
      if (ram_wrb) mem[ram_addrb] <= ram_dib;
      ram_doa <= mem[ram_addra];
      ram_dob <= mem[ram_addrb];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Response scoreboard: expected arrival cycle and data per channel.
  typedef struct {int c; int d;} exp_t;
  exp_t a_exp[$];
  exp_t b_exp[$];
  exp_t ea, eb;

  task automatic push_a(input int c, input int d);
    a_exp.push_back('{c, d});
  endtask
  task automatic push_b(input int c, input int d);
    b_exp.push_back('{c, d});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_rvalid) begin
        if (a_exp.size() == 0) chk("a_rvalid_unexpected", int'(a_rvalid), 0);
        else begin
          ea = a_exp.pop_front();
          chk("a_rlatency_cycle", cyc, ea.c);
          chk("a_rdata", int'(a_rdata), ea.d);
        end
      end
      if (b_rvalid) begin
        if (b_exp.size() == 0) chk("b_rvalid_unexpected", int'(b_rvalid), 0);
        else begin
          eb = b_exp.pop_front();
          chk("b_rlatency_cycle", cyc, eb.c);
          chk("b_rdata", int'(b_rdata), eb.d);
        end
      end
    end
  end

  task automatic drive(input int av, input int awr, input int aa, input int ad,
                       input int bv, input int bwr, input int ba, input int bd);
    a_valid = av[0];  a_wr = awr[0];  a_addr = aa[4:0];  a_wdata = ad[3:0];
    b_valid = bv[0];  b_wr = bwr[0];  b_addr = ba[4:0];  b_wdata = bd[3:0];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  typedef struct {
    int av, awr, aa, ad, bv, bwr, ba, bd;
    int ear, ebr, erda, erdb, ecoll;
  } vec_t;

  function automatic vec_t mk(input int av, awr, aa, ad, bv, bwr, ba, bd,
                              input int ear, ebr, erda, erdb, ecoll);
    vec_t v;
    v.av = av; v.awr = awr; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bwr = bwr; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.erda = erda; v.erdb = erdb; v.ecoll = ecoll;
    return v;
  endfunction

  vec_t vecs[15];
  int   wdat[32];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    //              A: v wr ad dat   B: v wr ad dat   rdyA rdyB rdA rdB coll
    vecs[0]  = mk(1, 1, 12, 12,  1, 1, 12,  7,   1, 0,  0,  0, 1); // conflict, A wins
    vecs[1]  = mk(0, 0,  0,  0,  1, 1, 12,  7,   1, 1,  0,  0, 1); // B held, accepted
    vecs[2]  = mk(1, 0, 12,  0,  0, 0,  0,  0,   1, 1,  7,  0, 1); // read 12 -> 7
    vecs[3]  = mk(1, 1, 12, 12,  1, 1, 12,  7,   0, 1,  0,  0, 2); // conflict, B wins
    vecs[4]  = mk(1, 1, 12, 12,  0, 0,  0,  0,   1, 1,  0,  0, 2); // A held, accepted
    vecs[5]  = mk(0, 0,  0,  0,  1, 0, 12,  0,   1, 1,  0, 12, 2); // read 12 -> 12
    vecs[6]  = mk(1, 0, 12,  0,  1, 0, 12,  0,   1, 1, 12, 12, 2); // dual read, no stall
    vecs[7]  = mk(1, 1, 31,  0,  1, 1,  0, 15,   1, 1,  0,  0, 2); // extremes
    vecs[8]  = mk(1, 0, 31,  0,  1, 0,  0,  0,   1, 1,  0, 15, 2);
    vecs[9]  = mk(1, 1,  0, 12,  1, 1, 31, 10,   1, 1,  0,  0, 2);
    vecs[10] = mk(1, 0,  0,  0,  1, 0, 31,  0,   1, 1, 12, 10, 2);
    vecs[11] = mk(1, 1,  5,  3,  1, 0,  5,  0,   1, 0,  0,  0, 3); // write vs read
    vecs[12] = mk(0, 0,  0,  0,  1, 0,  5,  0,   1, 1,  0,  3, 3); // sees new data
    vecs[13] = mk(1, 0,  5,  0,  1, 1,  5,  9,   0, 1,  0,  0, 4); // B wins
    vecs[14] = mk(1, 0,  5,  0,  0, 0,  0,  0,   1, 1,  9,  0, 4);

    // Reset state: valid conflicting requests must not be accepted.
    rst = 1'b1;
    drive(1, 1, 3, 3, 1, 1, 3, 4);
    @(negedge clk);
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
    chk("rst_ram_cs", int'(ram_cs), 0);
    chk("rst_ram_wra_wrb", int'({ram_wra, ram_wrb}), 0);
    chk("rst_ram_addr", int'({ram_addra, ram_addrb}), 0);
    chk("rst_ram_di", int'({ram_dia, ram_dib}), 0);
    chk("rst_rvalid", int'({a_rvalid, b_rvalid}), 0);
    chk("rst_rdata", int'({a_rdata, b_rdata}), 0);
    chk("rst_coll_cnt", int'(coll_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Table-driven vectors, one per cycle.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].awr, vecs[i].aa, vecs[i].ad,
            vecs[i].bv, vecs[i].bwr, vecs[i].ba, vecs[i].bd);
      #1;
      chk($sformatf("v%0d_a_ready", i), int'(a_ready), vecs[i].ear);
      chk($sformatf("v%0d_b_ready", i), int'(b_ready), vecs[i].ebr);
      if (vecs[i].av == 1 && vecs[i].awr == 0 && vecs[i].ear == 1) push_a(cyc + 3, vecs[i].erda);
      if (vecs[i].bv == 1 && vecs[i].bwr == 0 && vecs[i].ebr == 1) push_b(cyc + 3, vecs[i].erdb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_coll_cnt", i), int'(coll_cnt), vecs[i].ecoll);
    end
    idle(1);
    #1;
    chk("busy_after_reads", int'(busy), 1);
    idle(4);
    chk("table_a_responses_left", a_exp.size(), 0);
    chk("table_b_responses_left", b_exp.size(), 0);

    // Back-to-back: A writes i, B reads i-1 in the same cycle.
    for (int i = 0; i < 32; i++) wdat[i] = int'($urandom_range(0, 15));
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      drive(i < 32 ? 1 : 0, 1, i, (i < 32) ? wdat[i] : 0, i > 0 ? 1 : 0, 0, i - 1, 0);
      #1;
      if (i < 32) chk($sformatf("b2b%0d_a_ready", i), int'(a_ready), 1);
      if (i > 0) begin
        chk($sformatf("b2b%0d_b_ready", i), int'(b_ready), 1);
        push_b(cyc + 3, wdat[i - 1]);
      end
    end
    idle(5);
    chk("b2b_b_responses_left", b_exp.size(), 0);
    chk("b2b_coll_cnt", int'(coll_cnt), 4);

    // Reset mid-stream: hand priority to B first, then reset with 3 reads in flight.
    @(negedge clk);
    drive(1, 1, 2, 1, 1, 1, 2, 2);
    #1;
    chk("pre_rst_a_ready", int'(a_ready), 1);
    chk("pre_rst_b_ready", int'(b_ready), 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 1, 2, 2);
    @(negedge clk);
    drive(1, 0, 1, 0, 1, 0, 3, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_coll_cnt", int'(coll_cnt), 0);
    chk("midrst_ram_cs", int'(ram_cs), 0);
    chk("midrst_rvalid", int'({a_rvalid, b_rvalid}), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    // Restart: priority must be back on A, stalled B keeps its request.
    @(negedge clk);
    drive(1, 1, 3, 5, 1, 1, 3, 6);
    #1;
    chk("restart_a_ready", int'(a_ready), 1);
    chk("restart_b_ready", int'(b_ready), 0);
    @(posedge clk);
    #1;
    chk("restart_coll_cnt", int'(coll_cnt), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 3, 6);
    #1;
    chk("restart_b_held_ready", int'(b_ready), 1);
    @(negedge clk);
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    #1;
    chk("restart_read_ready", int'(a_ready), 1);
    push_a(cyc + 3, 6);
    idle(5);
    chk("restart_a_responses_left", a_exp.size(), 0);

    // Saturation: 300 consecutive conflicts from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1, 1, 1, 4, 1, 1, 1, 11);
      #1;
      chk($sformatf("sat%0d_a_ready", i), int'(a_ready), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("sat%0d_b_ready", i), int'(b_ready), (i % 2 == 1) ? 1 : 0);
      @(posedge clk);
      #1;
      if (i == 253) chk("sat_coll_254", int'(coll_cnt), 254);
      if (i == 254) chk("sat_coll_255", int'(coll_cnt), 255);
      if (i == 299) chk("sat_coll_hold", int'(coll_cnt), 255);
    end
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("sat_read_ready", int'(a_ready), 1);
    push_a(cyc + 3, 11);
    idle(5);
    chk("sat_a_responses_left", a_exp.size(), 0);
    chk("final_b_responses_left", b_exp.size(), 0);
    chk("final_coll_cnt", int'(coll_cnt), 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
